// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and default widths for the SRAM port arbiter slice.
//   arbState_e : arbiter FSM encoding (IDLE, BUSY_D, BUSY_I)
//   owner_e    : which requester owns / wins the SRAM (NONE, D, I)
//   *_W_DEF    : default address, write-data and read-line widths
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LINE_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arbState_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_D    = 2'd1,
    OWNER_I    = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arb_timeout.sv
// ---------------------------------------------------------------------------
// sram_arb_timeout
// Watchdog for a granted SRAM access. The counter is cleared when an access
// is granted and advances once per busy cycle; when it reaches TIMEOUT_CYC
// the sticky error flag sets. Only reset clears the flag. TIMEOUT_CYC = 0
// disables the watchdog entirely.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clr_i  in  restart the count (grant cycle)
//   inc_i  in  count one busy cycle
//   err_o  out sticky timeout flag
// ---------------------------------------------------------------------------
module sram_arb_timeout #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic err_o
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // The counter saturates at the limit so a very long stall cannot wrap it;
  // the error is raised on the same edge the count reaches the limit.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (TIMEOUT_CYC != 0) && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(TIMEOUT_CYC)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one SramController between the data-side cache (D port, read/write)
// and the instruction refill path (I port, read-only). The winning request is
// latched in IDLE and held on the SRAM interface until sramReadyIn; read data
// and completion are routed back to the owning port.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// of simultaneous requests (otherwise D has fixed priority over I).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dRdEnIn/dWrEnIn/dAdrIn/dWDataIn  D port request (held until dReadyOut)
//   dRDataOut/dReadyOut           D port read line and readiness
//   iRdEnIn/iAdrIn                I port read request
//   iRDataOut/iReadyOut           I port read line and readiness
//   sramWrEnOut/sramRdEnOut/sramAdrOut/sramWDataOut  to SramController
//   sramRDataIn/sramReadyIn       from SramController
//   errOut                        sticky access-timeout flag
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dRdEnIn,
  input  logic              dWrEnIn,
  input  logic [ADDR_W-1:0] dAdrIn,
  input  logic [DATA_W-1:0] dWDataIn,
  output logic [LINE_W-1:0] dRDataOut,
  output logic              dReadyOut,
  input  logic              iRdEnIn,
  input  logic [ADDR_W-1:0] iAdrIn,
  output logic [LINE_W-1:0] iRDataOut,
  output logic              iReadyOut,
  output logic              sramWrEnOut,
  output logic              sramRdEnOut,
  output logic [ADDR_W-1:0] sramAdrOut,
  output logic [DATA_W-1:0] sramWDataOut,
  input  logic [LINE_W-1:0] sramRDataIn,
  input  logic              sramReadyIn,
  output logic              errOut
);

  arbState_e         state_q, state_d;
  owner_e            grant;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] dRData_q, iRData_q;
  logic              dReq, iReq, busy, dDone, iDone, grantValid;

  assign dReq       = dRdEnIn | dWrEnIn;
  assign iReq       = iRdEnIn;
  assign busy       = (state_q != IDLE);
  assign dDone      = (state_q == BUSY_D) & sramReadyIn;
  assign iDone      = (state_q == BUSY_I) & sramReadyIn;
  assign grantValid = (state_q == IDLE) & (grant != OWNER_NONE);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Remembers the most recent winner so a tie goes to the other port.
  owner_e lastOwner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastOwner_q <= OWNER_I;
    end else if (grantValid) begin
      lastOwner_q <= grant;
    end
  end
`endif

  // Pick a winner among the currently pending requests; only used in IDLE.
  always_comb begin
    grant = OWNER_NONE;
    if (dReq && iReq) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (lastOwner_q == OWNER_D) begin
        grant = OWNER_I;
      end else begin
        grant = OWNER_D;
      end
`else
      grant = OWNER_D;
`endif
    end else if (dReq) begin
      grant = OWNER_D;
    end else if (iReq) begin
      grant = OWNER_I;
    end
  end

  // A simultaneous D read+write is taken as a write. The latched request is
  // frozen for the whole busy period, and every access returns through IDLE.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (grant == OWNER_D) begin
          state_d = BUSY_D;
          adr_d   = dAdrIn;
          wdata_d = dWDataIn;
          wr_d    = dWrEnIn;
        end else if (grant == OWNER_I) begin
          state_d = BUSY_I;
          adr_d   = iAdrIn;
          wr_d    = 1'b0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (sramReadyIn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      dRData_q <= '0;
      iRData_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      if (dDone && !wr_q) begin
        dRData_q <= sramRDataIn;
      end
      if (iDone) begin
        iRData_q <= sramRDataIn;
      end
    end
  end

  // Enables follow the latched op for as long as the access is in service.
  assign sramWrEnOut  = busy & wr_q;
  assign sramRdEnOut  = busy & ~wr_q;
  assign sramAdrOut   = adr_q;
  assign sramWDataOut = wdata_q;

  // Ready is raised in the completion cycle itself, so the returned line is
  // bypassed straight through then and held by the register afterwards.
  assign dReadyOut = ~dReq | dDone;
  assign iReadyOut = ~iReq | iDone;
  assign dRDataOut = (dDone && !wr_q) ? sramRDataIn : dRData_q;
  assign iRDataOut = iDone ? sramRDataIn : iRData_q;

  sram_arb_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uTimeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(grantValid),
    .inc_i(busy),
    .err_o(errOut)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
// Self-checking bench for sram_port_arbiter: a table of single-request
// vectors, directed multi-cycle sequences, and a randomized run checked
// against a transaction-level reference model. A small SRAM model inside
// the bench answers each access after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int LINE_W      = 64;
  localparam int TIMEOUT_CYC = 8;
  localparam logic [31:0] DADR = 32'h0000_1000;
  localparam logic [31:0] IADR = 32'h0000_2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              dRdEnIn, dWrEnIn, iRdEnIn;
  logic [ADDR_W-1:0] dAdrIn, iAdrIn;
  logic [DATA_W-1:0] dWDataIn;
  logic [LINE_W-1:0] dRDataOut, iRDataOut;
  logic              dReadyOut, iReadyOut;
  logic              sramWrEnOut, sramRdEnOut;
  logic [ADDR_W-1:0] sramAdrOut;
  logic [DATA_W-1:0] sramWDataOut;
  logic [LINE_W-1:0] sramRDataIn = '0;
  logic              sramReadyIn = 1'b0;
  logic              errOut;

  int          vecCount = 0;
  int          missCount = 0;
  int          enCnt = 0;
  int          sramLat = 1;
  bit          neverReady = 1'b0;
  bit          randMode = 1'b0;
  logic [63:0] sramData = '0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .dRdEnIn(dRdEnIn), .dWrEnIn(dWrEnIn), .dAdrIn(dAdrIn), .dWDataIn(dWDataIn),
    .dRDataOut(dRDataOut), .dReadyOut(dReadyOut),
    .iRdEnIn(iRdEnIn), .iAdrIn(iAdrIn), .iRDataOut(iRDataOut), .iReadyOut(iReadyOut),
    .sramWrEnOut(sramWrEnOut), .sramRdEnOut(sramRdEnOut), .sramAdrOut(sramAdrOut),
    .sramWDataOut(sramWDataOut), .sramRDataIn(sramRDataIn), .sramReadyIn(sramReadyIn),
    .errOut(errOut)
  );

  typedef struct {
    logic        dRd, dWr, iRd;
    logic        expDReady, expIReady;
    logic        expWr, expRd;
    logic [31:0] expAdr;
  } vec_t;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: edge, then the SRAM model reacts to the enables now showing.
  // Ready pulses in the sramLat-th enabled cycle; off-pulse data is inverted.
  task automatic step();
    @(posedge clk);
    #1;
    if (sramRdEnOut || sramWrEnOut) begin
      enCnt++;
      if (enCnt == 1 && randMode) begin
        sramLat  = $urandom_range(1, 5);
        sramData = {$urandom, $urandom};
      end
      sramReadyIn = !neverReady && (enCnt >= sramLat);
    end else begin
      enCnt       = 0;
      sramReadyIn = 1'b0;
    end
    sramRDataIn = sramReadyIn ? sramData : ~sramData;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    dRdEnIn = 0; dWrEnIn = 0; iRdEnIn = 0;
    dAdrIn = '0; iAdrIn = '0; dWDataIn = '0;
    randMode = 1'b0; neverReady = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Called in an enabled cycle; steps until the SRAM completes (bounded),
  // then takes the completion edge.
  task automatic waitDone(input string nm);
    int n = 0;
    while (!sramReadyIn && n < 40) begin
      step();
      n++;
    end
    checkOutput({nm, "_done"}, {63'd0, sramReadyIn}, 64'd1);
    step();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    doReset();
    sramLat = 1;
    dRdEnIn = v.dRd; dWrEnIn = v.dWr; iRdEnIn = v.iRd;
    dAdrIn = DADR; iAdrIn = IADR; dWDataIn = 32'hCAFE_0000 + idx;
    #1;
    checkOutput($sformatf("tbl%0d_dReady", idx), dReadyOut, v.expDReady);
    checkOutput($sformatf("tbl%0d_iReady", idx), iReadyOut, v.expIReady);
    step();
    checkOutput($sformatf("tbl%0d_sramWr", idx), sramWrEnOut, v.expWr);
    checkOutput($sformatf("tbl%0d_sramRd", idx), sramRdEnOut, v.expRd);
    checkOutput($sformatf("tbl%0d_sramAdr", idx), sramAdrOut, v.expAdr);
    if (v.expWr || v.expRd) waitDone($sformatf("tbl%0d", idx));
    dRdEnIn = 0; dWrEnIn = 0; iRdEnIn = 0;
    step();
  endtask

  task automatic testTable();
    vec_t vecs[8];
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DADR};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, DADR};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, DADR};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, IADR};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DADR};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, DADR};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, DADR};
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
  endtask

  // D read with 5-cycle SRAM; address wiggled mid-access must not leak out.
  task automatic testRead();
    int enCycles = 0;
    int k = 0;
    doReset();
    checkOutput("rst_sramAdr", sramAdrOut, 0);
    checkOutput("rst_err", errOut, 0);
    checkOutput("rst_dData", dRDataOut, 0);
    sramLat  = 5;
    sramData = 64'hA5A5_0000_1234_5678;
    dRdEnIn = 1; dAdrIn = 32'h40;
    #1;
    checkOutput("rd_readyLow", dReadyOut, 0);
    step();
    checkOutput("rd_minLatency", sramRdEnOut, 1);
    while (sramRdEnOut && k < 20) begin
      enCycles++;
      k++;
      checkOutput("rd_readyTiming", dReadyOut, (enCycles == 5));
      checkOutput("rd_adrStable", sramAdrOut, 32'h40);
      if (enCycles == 5) checkOutput("rd_data", dRDataOut, 64'hA5A5_0000_1234_5678);
      if (enCycles == 2) dAdrIn = 32'h44;
      step();
    end
    dRdEnIn = 0;
    checkOutput("rd_enCycles", enCycles, 5);
    #1;
    checkOutput("rd_dataHold", dRDataOut, 64'hA5A5_0000_1234_5678);
    step();
    checkOutput("rd_dataHold2", dRDataOut, 64'hA5A5_0000_1234_5678);
  endtask

  // Simultaneous D write and I read: D first, one idle cycle, then I.
  task automatic testConflict();
    int k = 0;
    doReset();
    sramLat = 3;
    dWrEnIn = 1; dAdrIn = 32'h80; dWDataIn = 32'h0000_BEEF;
    iRdEnIn = 1; iAdrIn = 32'h100;
    #1;
    checkOutput("cf_iReadyIdle", iReadyOut, 0);
    step();
    checkOutput("cf_wr", sramWrEnOut, 1);
    checkOutput("cf_rd", sramRdEnOut, 0);
    checkOutput("cf_adrD", sramAdrOut, 32'h80);
    checkOutput("cf_wdata", sramWDataOut, 32'h0000_BEEF);
    while (!sramReadyIn && k < 20) begin
      checkOutput("cf_iWait", iReadyOut, 0);
      step();
      k++;
    end
    checkOutput("cf_iWaitDone", iReadyOut, 0);
    checkOutput("cf_dDone", dReadyOut, 1);
    step();
    dWrEnIn = 0;
    checkOutput("cf_idleGap", sramWrEnOut | sramRdEnOut, 0);
    checkOutput("cf_iIdle", iReadyOut, 0);
    step();
    checkOutput("cf_iRd", sramRdEnOut, 1);
    checkOutput("cf_adrI", sramAdrOut, 32'h100);
    waitDone("cf_i");
    iRdEnIn = 0;
    step();
  endtask

  // Four tie rounds; each round both ports drop after the winner finishes.
  task automatic testRounds();
    int winner, exp;
    doReset();
    sramLat = 2;
    for (int r = 0; r < 4; r++) begin
      dWrEnIn = 1; dAdrIn = 32'h80; dWDataIn = 32'h0000_BEEF;
      iRdEnIn = 1; iAdrIn = 32'h100;
      step();
      winner = sramWrEnOut ? 1 : ((sramRdEnOut && sramAdrOut == 32'h100) ? 2 : 0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp = (r % 2 == 0) ? 1 : 2;
`else
      exp = 1;
`endif
      checkOutput($sformatf("order_round%0d", r), winner, exp);
      waitDone($sformatf("order_round%0d", r));
      dWrEnIn = 0; iRdEnIn = 0;
      step();
    end
  endtask

  task automatic testResetMid();
    doReset();
    neverReady = 1;
    dRdEnIn = 1; dAdrIn = 32'h40;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    checkOutput("rstMid_rdEn", sramRdEnOut, 0);
    checkOutput("rstMid_err", errOut, 0);
    checkOutput("rstMid_dReady", dReadyOut, 0);
    step();
    checkOutput("rstMid_rearb", sramRdEnOut, 1);
    neverReady = 0;
    sramLat = 1;
    waitDone("rstMid");
    dRdEnIn = 0;
    step();
  endtask

  task automatic testTimeout();
    doReset();
    neverReady = 1;
    dRdEnIn = 1; dAdrIn = 32'h300;
    step();
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("to_errLow%0d", k), errOut, 0);
      step();
    end
    checkOutput("to_errHigh", errOut, 1);
    checkOutput("to_stillBusy", sramRdEnOut, 1);
    step();
    step();
    checkOutput("to_errHeld", errOut, 1);
    neverReady = 0;
    sramLat = 1;
    waitDone("to");
    dRdEnIn = 0;
    step();
    checkOutput("to_errSticky", errOut, 1);
    doReset();
    checkOutput("to_errCleared", errOut, 0);
  endtask

  // Reference model: works per transaction. A port with a request pending in
  // an idle cycle must be served on the next cycle, the winner follows the
  // arbitration rule, the latched address holds until completion, and each
  // port's read line equals the last line returned to it.
  task automatic testRandom();
    int          lastOwn = 2;
    int          curOwn = 0;
    bit          prevEn = 0, prevReady = 0, en, expEn;
    bit          dPend, iPend, dBoth;
    logic        latWr = 0;
    logic [31:0] latAdr = 0, latWData = 0;
    logic [63:0] dHold = 0, iHold = 0;
    logic        expDR, expIR;
    int          op;
    doReset();
    randMode = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      en    = sramRdEnOut | sramWrEnOut;
      dPend = dRdEnIn | dWrEnIn;
      iPend = iRdEnIn;
      expEn = prevEn ? !prevReady : (dPend | iPend);
      checkOutput("rnd_enable", en, expEn);
      if (en && !prevEn && expEn) begin
        dBoth = dPend && iPend;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        curOwn = dBoth ? ((lastOwn == 1) ? 2 : 1) : (dPend ? 1 : 2);
`else
        curOwn = dPend ? 1 : 2;
`endif
        lastOwn = curOwn;
        if (curOwn == 1) begin
          latWr = dWrEnIn; latAdr = dAdrIn; latWData = dWDataIn;
        end else begin
          latWr = 1'b0; latAdr = iAdrIn;
        end
        checkOutput("rnd_grantWr", sramWrEnOut, latWr);
        checkOutput("rnd_grantRd", sramRdEnOut, !latWr);
        if (latWr) checkOutput("rnd_grantWData", sramWDataOut, latWData);
      end
      if (en) checkOutput("rnd_adr", sramAdrOut, latAdr);
      expDR = !dPend || (en && curOwn == 1 && sramReadyIn);
      expIR = !iPend || (en && curOwn == 2 && sramReadyIn);
      checkOutput("rnd_dReady", dReadyOut, expDR);
      checkOutput("rnd_iReady", iReadyOut, expIR);
      if (en && sramReadyIn && !latWr) begin
        if (curOwn == 1) dHold = sramData;
        else iHold = sramData;
      end
      checkOutput("rnd_dData", dRDataOut, dHold);
      checkOutput("rnd_iData", iRDataOut, iHold);
      if (en && sramReadyIn && curOwn == 1) begin
        dRdEnIn = 0; dWrEnIn = 0;
      end else if (!dPend && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2);
        dRdEnIn  = (op != 1);
        dWrEnIn  = (op != 0);
        dAdrIn   = {$urandom_range(0, 255), 2'b00};
        dWDataIn = $urandom;
      end
      if (en && sramReadyIn && curOwn == 2) begin
        iRdEnIn = 0;
      end else if (!iPend && $urandom_range(0, 2) == 0) begin
        iRdEnIn = 1;
        iAdrIn  = {$urandom_range(256, 511), 2'b00};
      end
      prevEn    = en;
      prevReady = sramReadyIn;
    end
    checkOutput("rnd_noErr", errOut, 0);
    randMode = 0;
  endtask

  // Test sequence: table vectors, directed corner cases, random, timeout.
  initial begin
    rst = 1'b1;
    dRdEnIn = 0; dWrEnIn = 0; iRdEnIn = 0;
    dAdrIn = '0; iAdrIn = '0; dWDataIn = '0;
    $display("[TB] starting sram_port_arbiter bench");
    testTable();
    testRead();
    testConflict();
    testRounds();
    testResetMid();
    testRandom();
    testTimeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
